// File: rtl/hazard_forward_unit.sv
// Load-use hazard detection and registered forwarding-select generation for a
// 5-stage MIPS pipeline; tracks EX/MEM destination so selects hold through EX.
module hazard_forward_unit #(
    parameter int STALL_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       IFtoID_Rs,
    input  logic [4:0]       IFtoID_Rt,
    input  logic             IFtoID_UsesRt,
    input  logic [4:0]       IDtoEX_WriteReg,
    input  logic             IDtoEX_RegWrite,
    input  logic             IDtoEX_MemRead,
    input  logic             BranchFlush,
    output logic             PCWrite,
    output logic             IFtoIDWrite,
    output logic             IDtoEXFlush,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic [CNT_W-1:0] StallCount
);

    localparam int HCW = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) + 1 : 1;
    localparam logic [HCW-1:0] HOLD_INIT = HCW'(STALL_CYCLES - 1);

    typedef enum logic {RUN, HOLD} state_e;

    state_e           state_q, state_d;
    logic [HCW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [4:0]       mem_dest_q;
    logic             mem_rw_q;
    logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             hazard, stall;

    // EX/MEM (instruction now in EX) is newer than MEM/WB, so it wins.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       ex_rw,
        input logic [4:0] ex_dest,
        input logic       mm_rw,
        input logic [4:0] mm_dest
    );
        if (ex_rw && ex_dest != 5'd0 && ex_dest == src)
            return 2'b10;
        else if (mm_rw && mm_dest != 5'd0 && mm_dest == src)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign hazard = IDtoEX_MemRead & IDtoEX_RegWrite & (IDtoEX_WriteReg != 5'd0) &
                    ((IDtoEX_WriteReg == IFtoID_Rs) |
                     (IFtoID_UsesRt & (IDtoEX_WriteReg == IFtoID_Rt)));

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        stall      = 1'b0;
        case (state_q)
            RUN: begin
                stall = hazard;
                if (hazard && STALL_CYCLES > 1) begin
                    state_d    = HOLD;
                    hold_cnt_d = HOLD_INIT;
                end
            end
            HOLD: begin
                stall      = 1'b1;
                hold_cnt_d = hold_cnt_q - HCW'(1);
                if (hold_cnt_q == HCW'(1)) begin
                    state_d    = RUN;
                    hold_cnt_d = '0;
                end
            end
            default: state_d = RUN;
        endcase
        // A taken branch squashes the stalled instruction, so the stall is moot.
        if (BranchFlush) begin
            stall      = 1'b0;
            state_d    = RUN;
            hold_cnt_d = '0;
        end
        if (rst)
            stall = 1'b0;
    end

    always_comb begin
        fwd_a_d = fwd_sel(IFtoID_Rs, IDtoEX_RegWrite, IDtoEX_WriteReg, mem_rw_q, mem_dest_q);
        fwd_b_d = fwd_sel(IFtoID_Rt, IDtoEX_RegWrite, IDtoEX_WriteReg, mem_rw_q, mem_dest_q);
        if (stall || BranchFlush) begin
            fwd_a_d = 2'b00;
            fwd_b_d = 2'b00;
        end
        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            hold_cnt_q  <= '0;
            mem_dest_q  <= 5'd0;
            mem_rw_q    <= 1'b0;
            fwd_a_q     <= 2'b00;
            fwd_b_q     <= 2'b00;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            mem_dest_q  <= IDtoEX_WriteReg;
            mem_rw_q    <= IDtoEX_RegWrite;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign PCWrite     = ~stall;
    assign IFtoIDWrite = ~stall;
    assign IDtoEXFlush = stall;
    assign ForwardA    = fwd_a_q;
    assign ForwardB    = fwd_b_q;
    assign StallCount  = stall_cnt_q;

endmodule
